// File: rtl/draw_pkg.sv
// Shared constants, types and helpers for the VGA draw chain.
package draw_pkg;
  localparam int COLOR_W    = 12;
  localparam int CNT_W      = 11;
  localparam int BOARD_W    = 1024;
  localparam int BOARD_H    = 768;
  localparam int DEF_GRID_N = 3;
  localparam int DEF_CELL_W = BOARD_W / DEF_GRID_N;
  localparam int DEF_CELL_H = BOARD_H / DEF_GRID_N;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } vga_timing_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction
endpackage

// File: rtl/cell_locator.sv
// Maps a pixel position onto the board grid: row/col by comparator chain,
// in-grid flag and (optionally) the pixel offset inside its cell.
module cell_locator
  import draw_pkg::*;
#(
  parameter int GRID_N    = DEF_GRID_N,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0,
  parameter int CELL_W    = DEF_CELL_W,
  parameter int CELL_H    = DEF_CELL_H,
  parameter bit OFFSET_EN = 1'b1,
  parameter int RC_W      = (clog2(GRID_N) < 1) ? 1 : clog2(GRID_N)
) (
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  output logic [RC_W-1:0]  row,
  output logic [RC_W-1:0]  col,
  output logic             in_grid,
  output logic [CNT_W-1:0] off_x,
  output logic [CNT_W-1:0] off_y
);

  always_comb begin
    int h, v, base_x, base_y;
    h      = int'(hcount);
    v      = int'(vcount);
    row    = '0;
    col    = '0;
    base_x = ORIGIN_X;
    base_y = ORIGIN_Y;
    // Each boundary passed moves the pixel one cell right/down; no divider.
    for (int k = 1; k < GRID_N; k++) begin
      if (h >= ORIGIN_X + k * CELL_W) begin
        col    = RC_W'(k);
        base_x = ORIGIN_X + k * CELL_W;
      end
      if (v >= ORIGIN_Y + k * CELL_H) begin
        row    = RC_W'(k);
        base_y = ORIGIN_Y + k * CELL_H;
      end
    end
    in_grid = (h >= ORIGIN_X) && (h < ORIGIN_X + GRID_N * CELL_W) &&
              (v >= ORIGIN_Y) && (v < ORIGIN_Y + GRID_N * CELL_H);
    off_x   = OFFSET_EN ? CNT_W'(h - base_x) : '0;
    off_y   = OFFSET_EN ? CNT_W'(v - base_y) : '0;
  end

endmodule

// File: rtl/draw_cell_highlight.sv
// Grid-cell highlighter: fills or blinks any subset of board cells, with cell selection
// latched at vblank start. Build macro HL_OUTLINE_EN paints only an OUTLINE_W-pixel cell border.
module draw_cell_highlight
  import draw_pkg::*;
#(
  parameter int GRID_N       = DEF_GRID_N,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int CELL_W       = DEF_CELL_W,
  parameter int CELL_H       = DEF_CELL_H,
  parameter int BLINK_FRAMES = 30,
  parameter int OUTLINE_W    = 4
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           hcount_in,
  input  logic [CNT_W-1:0]           vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [COLOR_W-1:0]         rgb_in,
  input  logic                       start_en,
  input  logic                       choice_en,
  input  logic [GRID_N*GRID_N-1:0]   cell_mask,
  input  logic [GRID_N*GRID_N-1:0]   blink_mask,
  input  logic [COLOR_W-1:0]         square_color,
  output logic [CNT_W-1:0]           hcount_out,
  output logic [CNT_W-1:0]           vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [COLOR_W-1:0]         rgb_out,
  output logic                       frame_tick
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int RC_W  = (clog2(GRID_N) < 1) ? 1 : clog2(GRID_N);
  localparam int IDX_W = (clog2(CELLS) < 1) ? 1 : clog2(CELLS);
  localparam int FC_W  = (clog2(BLINK_FRAMES) < 1) ? 1 : clog2(BLINK_FRAMES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
`ifdef HL_OUTLINE_EN
  localparam bit OUTLINE_ON = 1'b1;
`else
  localparam bit OUTLINE_ON = 1'b0;
`endif

  logic [RC_W-1:0]  row, col;
  logic             in_grid;
  logic [CNT_W-1:0] off_x, off_y;
  logic             outline_hit;

  vga_timing_t        tim_p1_d, tim_p1_q, tim_p2_d, tim_p2_q;
  logic [COLOR_W-1:0] rgb_p1_d, rgb_p1_q, color_p1_d, color_p1_q, rgb_p2_d, rgb_p2_q;
  logic [IDX_W-1:0]   idx_p1_d, idx_p1_q;
  logic               paint_p1_d, paint_p1_q;

  logic               vsync_prev_d, vsync_prev_q, vblnk_prev_d, vblnk_prev_q;
  logic [CELLS-1:0]   shadow_cell_d, shadow_cell_q, shadow_blink_d, shadow_blink_q;
  logic               shadow_en_d, shadow_en_q;
  logic [FC_W-1:0]    fcnt_d, fcnt_q;
  logic               phase_d, phase_q;
  logic               frame_tick_d, frame_tick_q;
  logic               vsync_rise, vblnk_rise, en_next, hit;

  cell_locator #(
    .GRID_N    (GRID_N),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y),
    .CELL_W    (CELL_W),
    .CELL_H    (CELL_H),
    .OFFSET_EN (OUTLINE_ON),
    .RC_W      (RC_W)
  ) u_locator (
    .hcount  (hcount_in),
    .vcount  (vcount_in),
    .row     (row),
    .col     (col),
    .in_grid (in_grid),
    .off_x   (off_x),
    .off_y   (off_y)
  );

`ifdef HL_OUTLINE_EN
  assign outline_hit = (int'(off_x) < OUTLINE_W) || (int'(off_x) >= CELL_W - OUTLINE_W) ||
                       (int'(off_y) < OUTLINE_W) || (int'(off_y) >= CELL_H - OUTLINE_W);
`else
  logic unused_ok;
  assign outline_hit = 1'b1;
  assign unused_ok   = &{1'b0, off_x, off_y, (OUTLINE_W > 0)};
`endif

  // Stage 1: delayed timing, pixel, colour and cell lookup
  always_comb begin
    tim_p1_d   = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                   vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
    rgb_p1_d   = rgb_in;
    color_p1_d = square_color;
    idx_p1_d   = IDX_W'(int'(row) * GRID_N + int'(col));
    paint_p1_d = in_grid && outline_hit;
  end

  // Frame control: shadow latch on vblank start, blink counter on vsync start
  always_comb begin
    vsync_rise     = vsync_in & ~vsync_prev_q;
    vblnk_rise     = vblnk_in & ~vblnk_prev_q;
    en_next        = start_en & ~choice_en;
    vsync_prev_d   = vsync_in;
    vblnk_prev_d   = vblnk_in;
    shadow_cell_d  = shadow_cell_q;
    shadow_blink_d = shadow_blink_q;
    shadow_en_d    = shadow_en_q;
    fcnt_d         = fcnt_q;
    phase_d        = phase_q;
    frame_tick_d   = vsync_rise;
    if (vblnk_rise) begin
      shadow_cell_d  = cell_mask;
      shadow_blink_d = blink_mask;
      shadow_en_d    = en_next;
    end
    // A fresh enable restarts blinking in the visible phase.
    if (vblnk_rise && en_next && !shadow_en_q) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (vsync_rise) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  // Stage 2: colour selection
  always_comb begin
    hit      = paint_p1_q && shadow_en_q && shadow_cell_q[idx_p1_q] &&
               !(shadow_blink_q[idx_p1_q] && phase_q) &&
               !tim_p1_q.hblnk && !tim_p1_q.vblnk;
    tim_p2_d = tim_p1_q;
    rgb_p2_d = hit ? color_p1_q : rgb_p1_q;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      tim_p1_q       <= '0;
      rgb_p1_q       <= '0;
      color_p1_q     <= '0;
      idx_p1_q       <= '0;
      paint_p1_q     <= 1'b0;
      tim_p2_q       <= '0;
      rgb_p2_q       <= '0;
      vsync_prev_q   <= 1'b0;
      vblnk_prev_q   <= 1'b0;
      shadow_cell_q  <= '0;
      shadow_blink_q <= '0;
      shadow_en_q    <= 1'b0;
      fcnt_q         <= '0;
      phase_q        <= 1'b0;
      frame_tick_q   <= 1'b0;
    end else begin
      tim_p1_q       <= tim_p1_d;
      rgb_p1_q       <= rgb_p1_d;
      color_p1_q     <= color_p1_d;
      idx_p1_q       <= idx_p1_d;
      paint_p1_q     <= paint_p1_d;
      tim_p2_q       <= tim_p2_d;
      rgb_p2_q       <= rgb_p2_d;
      vsync_prev_q   <= vsync_prev_d;
      vblnk_prev_q   <= vblnk_prev_d;
      shadow_cell_q  <= shadow_cell_d;
      shadow_blink_q <= shadow_blink_d;
      shadow_en_q    <= shadow_en_d;
      fcnt_q         <= fcnt_d;
      phase_q        <= phase_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign hcount_out = tim_p2_q.hcount;
  assign vcount_out = tim_p2_q.vcount;
  assign hsync_out  = tim_p2_q.hsync;
  assign vsync_out  = tim_p2_q.vsync;
  assign hblnk_out  = tim_p2_q.hblnk;
  assign vblnk_out  = tim_p2_q.vblnk;
  assign rgb_out    = rgb_p2_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_draw_cell_highlight.sv
// Bench for draw_cell_highlight: randomized pixels and frame events checked against
// an arithmetic reference model (division-based cell lookup, frames-since-restart blink).
`timescale 1ns/1ps
module tb_draw_cell_highlight;
  localparam int N     = 3;
  localparam int OX    = 0;
  localparam int OY    = 0;
  localparam int CW    = 341;
  localparam int CH    = 256;
  localparam int BF    = 2;
  localparam int OW    = 4;
  localparam int CELLS = N * N;

  logic             pclk = 1'b0;
  logic             rst;
  logic [10:0]      hcount_in, vcount_in;
  logic             hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]      rgb_in;
  logic             start_en, choice_en;
  logic [CELLS-1:0] cell_mask, blink_mask;
  logic [11:0]      square_color;
  logic [10:0]      hcount_out, vcount_out;
  logic             hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]      rgb_out;
  logic             frame_tick;

  always #5 pclk = ~pclk;

  draw_cell_highlight #(
    .GRID_N(N), .ORIGIN_X(OX), .ORIGIN_Y(OY), .CELL_W(CW), .CELL_H(CH),
    .BLINK_FRAMES(BF), .OUTLINE_W(OW)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en),
    .cell_mask(cell_mask), .blink_mask(blink_mask), .square_color(square_color),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [25:0] tim;
    logic [11:0] rgb;
  } exp_t;

  logic [CELLS-1:0] m_cell, m_blink;
  logic             m_en, m_vs_prev, m_vb_prev;
  int               m_frames;
  exp_t             pipe1, pipe2;
  int               n_pass = 0;
  int               n_total = 0;

  function automatic logic [11:0] model_pixel(input int h, input int v, input logic hb,
                                              input logic vb, input logic [11:0] rgb);
    int  c, r, i;
    bit  hidden;
    if (!m_en || hb || vb) return rgb;
    if (h < OX || h >= OX + N * CW || v < OY || v >= OY + N * CH) return rgb;
    c = (h - OX) / CW;
    r = (v - OY) / CH;
    i = r * N + c;
`ifdef HL_OUTLINE_EN
    if ((h - OX) % CW >= OW && (h - OX) % CW < CW - OW &&
        (v - OY) % CH >= OW && (v - OY) % CH < CH - OW) return rgb;
`endif
    hidden = ((m_frames / BF) % 2) == 1;
    if (!m_cell[i] || (m_blink[i] && hidden)) return rgb;
    return square_color;
  endfunction

  task automatic step(input int h, input int v, input logic hs, input logic vs,
                      input logic hb, input logic vb);
    exp_t now;
    logic tick, vs_rise, vb_rise, restart;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = 12'($urandom);
    tick      = 1'b0;
    if (rst) begin
      m_cell = '0; m_blink = '0; m_en = 1'b0;
      m_vs_prev = 1'b0; m_vb_prev = 1'b0; m_frames = 0;
      pipe1 = '0; pipe2 = '0;
    end else begin
      vs_rise = vs && !m_vs_prev;
      vb_rise = vb && !m_vb_prev;
      restart = 1'b0;
      if (vb_rise) begin
        restart = start_en && !choice_en && !m_en;
        m_cell  = cell_mask;
        m_blink = blink_mask;
        m_en    = start_en && !choice_en;
      end
      if (restart) m_frames = 0;
      else if (vs_rise) m_frames++;
      m_vs_prev = vs;
      m_vb_prev = vb;
      now.tim = {11'(h), 11'(v), hs, vs, hb, vb};
      now.rgb = model_pixel(h, v, hb, vb, rgb_in);
      pipe2 = pipe1;
      pipe1 = now;
      tick  = vs_rise;
    end
    @(posedge pclk);
    #1;
    n_total++;
    assert (rgb_out === pipe2.rgb) n_pass++;
    else $error("FAIL rgb at h=%0d v=%0d: got %h want %h", pipe2.tim[25:15], pipe2.tim[14:4], rgb_out, pipe2.rgb);
    n_total++;
    assert ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} === pipe2.tim) n_pass++;
    else $error("FAIL timing: got %h want %h",
                {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, pipe2.tim);
    n_total++;
    assert (frame_tick === tick) n_pass++;
    else $error("FAIL frame_tick: got %b want %b", frame_tick, tick);
  endtask

  function automatic int pick_h();
    int edges [7] = '{0, 340, 341, 681, 682, 1022, 1023};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 6)];
    return int'($urandom_range(0, 1100));
  endfunction

  function automatic int pick_v();
    int edges [7] = '{0, 255, 256, 511, 512, 767, 768};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 6)];
    return int'($urandom_range(0, 800));
  endfunction

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++)
      step(pick_h(), pick_v(), 1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 7) == 0), 1'b0);
  endtask

  task automatic vblank(input bit coincide);
    if (!coincide)
      for (int i = 0; i < 2; i++) step(pick_h(), pick_v(), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 3; i++) step(pick_h(), pick_v(), 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 2; i++) step(pick_h(), pick_v(), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic cell8_pixels(input int n);
    for (int i = 0; i < n; i++)
      step(int'($urandom_range(682, 1022)), int'($urandom_range(512, 767)), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start_en = 1'b1; choice_en = 1'b0;
    cell_mask = '1; blink_mask = '0; square_color = 12'hF0A;
    for (int i = 0; i < 3; i++)
      step(pick_h(), pick_v(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b0;
    start_en = 1'b0;
    pixels(20);

    // Single cell 2 selected at vblank start
    cell_mask = 9'h004; start_en = 1'b1;
    vblank(1'b0);
    step(682, 0, 0, 0, 0, 0);   step(1022, 255, 0, 0, 0, 0);
    step(681, 10, 0, 0, 0, 0);  step(1023, 10, 0, 0, 0, 0);
    step(700, 100, 0, 0, 1, 0); step(341, 0, 0, 0, 0, 0);
    pixels(60);

    // Mid-frame mask switch only applies next frame
    step(500, 300, 0, 0, 0, 0);
    cell_mask = 9'h010;
    step(800, 100, 0, 0, 0, 0); step(400, 300, 0, 0, 0, 0);
    pixels(60);
    vblank(1'b0);
    step(341, 256, 0, 0, 0, 0); step(681, 511, 0, 0, 0, 0);
    step(340, 256, 0, 0, 0, 0); step(682, 300, 0, 0, 0, 0);
    step(800, 100, 0, 0, 0, 0); step(400, 767, 0, 0, 0, 0);
    pixels(60);

    // Blinking cell 8 over several frames, one with coincident vsync/vblank edges
    cell_mask = 9'h100; blink_mask = 9'h100;
    for (int f = 0; f < 7; f++) begin
      vblank(f == 3);
      cell8_pixels(12);
      pixels(10);
    end

    // Choice screen suppresses everything
    choice_en = 1'b1; cell_mask = 9'h1FF; blink_mask = '0;
    vblank(1'b0);
    pixels(80);

    // Re-enable restarts the blink, then random masks and events
    choice_en = 1'b0; cell_mask = 9'h1FF; blink_mask = 9'h0F0;
    for (int f = 0; f < 10; f++) begin
      vblank(($urandom_range(0, 2) == 0));
      cell8_pixels(8);
      pixels(40);
      cell_mask  = 9'($urandom);
      blink_mask = 9'($urandom);
      start_en   = ($urandom_range(0, 4) != 0);
      choice_en  = ($urandom_range(0, 5) == 0);
      pixels(30);
    end

    // Reset mid-frame: empty shadows until next vblank start
    start_en = 1'b1; choice_en = 1'b0; cell_mask = '1; blink_mask = '0;
    pixels(5);
    rst = 1'b1;
    square_color = 12'h3C5;
    step(700, 100, 0, 0, 0, 0);
    rst = 1'b0;
    pixels(40);
    vblank(1'b0);
    pixels(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
